// File: rtl/instr_stream_loader_pkg.sv
// Shared constants and state encodings for the serial instruction loader.
package instr_stream_loader_pkg;

    localparam int unsigned CLK_HZ               = 50_000_000;
    localparam int unsigned BAUD                 = 115_200;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD;
    localparam logic [7:0]  HEADER_BYTE_DEFAULT  = 8'hA5;
    localparam int unsigned WORD_W               = 16;
    localparam int unsigned REM_W                = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_CHECK
    } load_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes rx, validates the start bit at mid-bit,
// samples data LSB first and reports a good byte or a framing error.
module uart_rx_byte
    import instr_stream_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    rx_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_byte_d;
    logic        byte_valid_d, frame_err_d;
    logic        rx_meta, rx_sync, rx_prev;
    logic        half_hit, full_hit;

    assign half_hit = (cnt_q == CNT_W'(HALF - 1));
    assign full_hit = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // State register plus all registered datapath and outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_byte    <= rx_byte_d;
            byte_valid <= byte_valid_d;
            frame_err  <= frame_err_d;
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (rx_prev && !rx_sync) state_d = RX_START;
            RX_START: if (half_hit) state_d = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_hit && (bit_q == 3'd7)) state_d = RX_STOP;
            RX_STOP:  if (full_hit) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            RX_START: if (half_hit) cnt_d = '0;
            RX_DATA: if (full_hit) begin
                cnt_d   = '0;
                shift_d = {rx_sync, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
            end
            RX_STOP: if (full_hit) begin
                cnt_d = '0;
                if (rx_sync) begin
                    byte_valid_d = 1'b1;
                    rx_byte_d    = shift_q;
                end else begin
                    frame_err_d  = 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

endmodule

// File: rtl/instr_stream_loader.sv
// Serial boot loader: parses header/count/data/checksum frames from the UART
// and writes big-endian words into instruction memory, gating the CPU reset.
module instr_stream_loader
    import instr_stream_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic [7:0]  HEADER_BYTE  = HEADER_BYTE_DEFAULT,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx,
    output logic [15:0]       instruction_out,
    output logic              load_instruction,
    output logic [ADDR_W-1:0] load_address,
    output logic              pc_reset_out,
    output logic              busy,
    output logic              done,
    output logic              error
);
    logic [7:0] rx_byte;
    logic       byte_valid, frame_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    load_state_e       state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] idx_q, idx_d, addr_d;
    logic [7:0]        hi_q, hi_d, acc_q, acc_d;
    logic [WORD_W-1:0] instr_d;
    logic              load_d, pc_reset_d, busy_d, done_d, error_d;
    logic              abort;

    // A framing error aborts any frame in progress; idle line noise is ignored
    assign abort = frame_err && (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            rem_q            <= '0;
            idx_q            <= '0;
            hi_q             <= '0;
            acc_q            <= '0;
            instruction_out  <= '0;
            load_instruction <= 1'b0;
            load_address     <= '0;
            pc_reset_out     <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            state_q          <= state_d;
            rem_q            <= rem_d;
            idx_q            <= idx_d;
            hi_q             <= hi_d;
            acc_q            <= acc_d;
            instruction_out  <= instr_d;
            load_instruction <= load_d;
            load_address     <= addr_d;
            pc_reset_out     <= pc_reset_d;
            busy             <= busy_d;
            done             <= done_d;
            error            <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (byte_valid && (rx_byte == HEADER_BYTE)) state_d = ST_COUNT;
                ST_COUNT: if (byte_valid) state_d = ST_HI;
                ST_HI:    if (byte_valid) state_d = ST_LO;
                ST_LO:    if (byte_valid) state_d = ST_WRITE;
                ST_WRITE: state_d = (rem_q == REM_W'(1)) ? ST_CHECK : ST_HI;
                ST_CHECK: if (byte_valid) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rem_d      = rem_q;
        idx_d      = idx_q;
        hi_d       = hi_q;
        acc_d      = acc_q;
        instr_d    = instruction_out;
        load_d     = 1'b0;
        addr_d     = load_address;
        pc_reset_d = pc_reset_out;
        busy_d     = busy;
        done_d     = done;
        error_d    = error;
        if (abort) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (byte_valid && (rx_byte == HEADER_BYTE)) begin
                    busy_d     = 1'b1;
                    pc_reset_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    addr_d     = '0;
                    idx_d      = '0;
                    acc_d      = '0;
                end
                // A count of zero encodes a full 256-word frame
                ST_COUNT: if (byte_valid) begin
                    rem_d = (rx_byte == 8'h00) ? REM_W'(256) : REM_W'(rx_byte);
                end
                ST_HI: if (byte_valid) begin
                    hi_d  = rx_byte;
                    acc_d = acc_q ^ rx_byte;
                end
                ST_LO: if (byte_valid) begin
                    acc_d   = acc_q ^ rx_byte;
                    instr_d = {hi_q, rx_byte};
                    load_d  = 1'b1;
                    addr_d  = idx_q;
                end
                ST_WRITE: begin
                    idx_d = idx_q + ADDR_W'(1);
                    rem_d = rem_q - REM_W'(1);
                end
                ST_CHECK: if (byte_valid) begin
                    busy_d = 1'b0;
                    if (rx_byte == acc_q) begin
                        done_d     = 1'b1;
                        pc_reset_d = 1'b0;
                    end else begin
                        error_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stream_loader.sv
// Randomized frame-level bench for instr_stream_loader with a word-list model
// of expected memory writes and final status flags.
module tb_instr_stream_loader;
    localparam int unsigned CPB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx;
    logic [15:0] instruction_out;
    logic        load_instruction;
    logic [15:0] load_address;
    logic        pc_reset_out, busy, done, error;

    instr_stream_loader #(
        .CLKS_PER_BIT (CPB),
        .HEADER_BYTE  (8'hA5),
        .ADDR_W       (16)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rx               (rx),
        .instruction_out  (instruction_out),
        .load_instruction (load_instruction),
        .load_address     (load_address),
        .pc_reset_out     (pc_reset_out),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          bv_cyc   = -100;
    int          bv_count = 0;
    int          consec   = 0;
    logic        prev_load = 1'b0;
    logic        prev_pc   = 1'b1;
    logic [31:0] obs_q[$];
    logic [15:0] words[256];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observe strobes and latencies relative to the receiver's byte pulse
    always @(negedge clk) begin
        if (load_instruction) begin
            obs_q.push_back({load_address, instruction_out});
            check_eq("wr_latency", 64'(cyc - bv_cyc), 64'd1);
            if (prev_load) consec++;
        end
        if (prev_pc && !pc_reset_out) check_eq("pc_fall_latency", 64'(cyc - bv_cyc), 64'd1);
        if (dut.u_rx.byte_valid) begin
            bv_cyc = cyc;
            bv_count++;
        end
        prev_load = load_instruction;
        prev_pc   = pc_reset_out;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        if (!stop_ok) begin
            send_bit(1'b1);
            send_bit(1'b1);
        end
        rx = 1'b1;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_instr"}, 64'(instruction_out), 64'd0);
        check_eq({tag, "_load"},  64'(load_instruction), 64'd0);
        check_eq({tag, "_addr"},  64'(load_address), 64'd0);
        check_eq({tag, "_pc"},    64'(pc_reset_out), 64'd1);
        check_eq({tag, "_busy"},  64'(busy), 64'd0);
        check_eq({tag, "_done"},  64'(done), 64'd0);
        check_eq({tag, "_err"},   64'(error), 64'd0);
    endtask

    // Send one frame built from words[0..nw-1]; bad_stop >= 0 gives the data
    // byte index whose stop bit is forced low (sending stops there).
    task automatic run_frame(input string tag, input int nw, input logic [7:0] csum_xor,
                             input int bad_stop);
        logic [7:0] csum;
        logic [7:0] b;
        logic       aborted;
        int         n_exp;
        logic       good;
        csum    = 8'h00;
        aborted = 1'b0;
        for (int i = 0; i < nw; i++) csum = csum ^ words[i][15:8] ^ words[i][7:0];
        csum = csum ^ csum_xor;
        obs_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'(nw), 1'b1);
        for (int j = 0; j < 2 * nw; j++) begin
            if (!aborted) begin
                b = (j % 2 == 0) ? words[j / 2][15:8] : words[j / 2][7:0];
                send_byte(b, j != bad_stop);
                if (j == bad_stop) aborted = 1'b1;
            end
        end
        if (!aborted) send_byte(csum, 1'b1);
        repeat (3 * CPB) @(negedge clk);

        n_exp = (bad_stop < 0) ? nw : bad_stop / 2;
        good  = (bad_stop < 0) && (csum_xor == 8'h00);
        check_eq({tag, "_nwrites"}, 64'(obs_q.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < obs_q.size(); i++)
            check_eq($sformatf("%s_w%0d", tag, i), 64'(obs_q[i]), 64'({16'(i), words[i]}));
        check_eq({tag, "_done"}, 64'(done), 64'(good));
        check_eq({tag, "_err"},  64'(error), 64'(!good));
        check_eq({tag, "_pc"},   64'(pc_reset_out), 64'(!good));
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic fill_random(input int nw);
        for (int i = 0; i < nw; i++) words[i] = 16'($urandom);
    endtask

    initial begin
        int bad;
        int nw;
        int bv_before;
        int kind;
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        reset_n = 1'b1;

        // Idle line after reset: nothing may move for 2000 cycles
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (instruction_out !== 16'h0 || load_instruction !== 1'b0 || load_address !== 16'h0 ||
                pc_reset_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) bad++;
        end
        check_eq("reset_hold", 64'(bad), 64'd0);

        // Reference frame and its corrupted-checksum twin
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        run_frame("ref_good", 2, 8'h00, -1);
        run_frame("ref_badsum", 2, 8'h01, -1);
        fill_random(3);
        run_frame("recover", 3, 8'h00, -1);

        // Stop bit low on the second data byte
        fill_random(2);
        run_frame("bad_stop", 2, 8'h00, 1);
        fill_random(2);
        run_frame("after_stop", 2, 8'h00, -1);

        // Full 256-word frame, word i = i
        for (int i = 0; i < 256; i++) words[i] = 16'(i);
        run_frame("full256", 256, 8'h00, -1);

        // Reset in the middle of a 5-word frame after 3 words
        fill_random(5);
        obs_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h05, 1'b1);
        for (int j = 0; j < 6; j++) send_byte((j % 2 == 0) ? words[j / 2][15:8] : words[j / 2][7:0], 1'b1);
        repeat (CPB) @(negedge clk);
        check_eq("mid_busy", 64'(busy), 64'd1);
        check_eq("mid_nwrites", 64'(obs_q.size()), 64'd3);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_outputs("mid_reset");
        fill_random(4);
        run_frame("post_reset", 4, 8'h00, -1);

        // Quarter-bit glitch on the idle line
        bv_before = bv_count;
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check_eq("glitch_bytes", 64'(bv_count - bv_before), 64'd0);
        check_eq("glitch_busy", 64'(busy), 64'd0);
        check_eq("glitch_err", 64'(error), 64'd0);

        // Random frames with random corruption
        for (int k = 0; k < 6; k++) begin
            nw   = $urandom_range(1, 8);
            kind = $urandom_range(0, 2);
            fill_random(nw);
            if (kind == 0)      run_frame($sformatf("rnd%0d_ok", k), nw, 8'h00, -1);
            else if (kind == 1) run_frame($sformatf("rnd%0d_sum", k), nw, 8'($urandom_range(1, 255)), -1);
            else                run_frame($sformatf("rnd%0d_stop", k), nw, 8'h00, $urandom_range(0, 2 * nw - 1));
        end

        check_eq("no_back_to_back", 64'(consec), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
